// File: rtl/counter_defs.sv
// ---------------------------------------------------------------------------
// counter_defs
// Definitions shared by the counter family so that every counter block uses
// the same state encoding and the same default width.
//   ST_IDLE / ST_RUN : counter state encoding (1 bit)
//   DEFAULT_WIDTH    : default count width in bits
// ---------------------------------------------------------------------------
package counter_defs;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : counter_defs

// File: rtl/sync_down_counter.sv
// ---------------------------------------------------------------------------
// sync_down_counter
// Loadable down-counter with a terminal-count pulse and optional periodic
// auto-reload. All state changes happen on the rising edge of clk.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous reset, active-high
//   load         load request; load_value goes into q and the reload register
//   load_value   start value (WIDTH bits)
//   en           count enable, one decrement per edge while running
//   auto_reload  1: periodic mode, 0: one-shot mode (sampled at terminal edge)
//   q            current count (registered)
//   tc           terminal-count pulse, one cycle wide (registered)
//   busy         high while the counter is running
// ---------------------------------------------------------------------------
module sync_down_counter
  import counter_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] rl;
  logic [WIDTH-1:0] rl_next;
  logic             tc_next;

  // Next-state logic. Load has priority over counting. The terminal edge is
  // the one taken at q=1, so q never decrements through zero: in periodic
  // mode it jumps straight back to the reload value, in one-shot mode it
  // lands on zero and the counter goes idle. A zero load parks the counter
  // in IDLE because there is nothing to count down.
  always_comb begin
    state_next = state;
    q_next     = q;
    rl_next    = rl;
    tc_next    = 1'b0;

    if (load) begin
      q_next     = load_value;
      rl_next    = load_value;
      state_next = (load_value != ZERO) ? ST_RUN : ST_IDLE;
    end else if (state == ST_RUN && en) begin
      if (q == ONE) begin
        tc_next = 1'b1;
        if (auto_reload) begin
          q_next = rl;
        end else begin
          q_next     = ZERO;
          state_next = ST_IDLE;
        end
      end else begin
        q_next = q - ONE;
      end
    end
  end

  // Single register bank for state, count, reload value and terminal pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      q     <= ZERO;
      rl    <= ZERO;
      tc    <= 1'b0;
    end else begin
      state <= state_next;
      q     <= q_next;
      rl    <= rl_next;
      tc    <= tc_next;
    end
  end

  // busy is just a decode of the state register.
  assign busy = (state == ST_RUN);

endmodule : sync_down_counter

// File: tb/tb_sync_down_counter.sv
// ---------------------------------------------------------------------------
// tb_sync_down_counter
// Self-checking bench for sync_down_counter: directed scenarios with fixed
// expected values, followed by randomized traffic compared against a
// behavioural model of the counter's rules.
// ---------------------------------------------------------------------------
module tb_sync_down_counter;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] load_value;
  logic         en;
  logic         auto_reload;
  logic [W-1:0] q;
  logic         tc;
  logic         busy;

  int checks;
  int failures;

  // Reference model: count value, saved reload value, running flag and
  // the expected terminal pulse after the most recent edge.
  int m_q;
  int m_rl;
  bit m_run;
  bit m_tc;

  int tc_seen;

  sync_down_counter #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_value  (load_value),
    .en          (en),
    .auto_reload (auto_reload),
    .q           (q),
    .tc          (tc),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on disagreement counts a failure and
  // reports tag, observed and expected values.
  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t",
               tag, observed, expected, $time);
      $error("[TB] %s disagrees with expected value", tag);
    end
  endtask

  // Model of one rising edge, written from the counter's behavioural rules.
  task automatic model_edge();
    if (reset) begin
      m_q = 0; m_rl = 0; m_run = 0; m_tc = 0;
    end else if (load) begin
      m_q   = int'(load_value);
      m_rl  = int'(load_value);
      m_run = (load_value != 0);
      m_tc  = 0;
    end else if (m_run && en && m_q == 1) begin
      m_tc = 1;
      if (auto_reload) begin
        m_q = m_rl;
      end else begin
        m_q   = 0;
        m_run = 0;
      end
    end else if (m_run && en) begin
      m_q  = m_q - 1;
      m_tc = 0;
    end else begin
      m_tc = 0;
    end
  endtask

  // Drive one set of inputs across one rising edge, then compare the DUT
  // against the model a little after the edge.
  task automatic applyStimulus(input logic r, input logic ld,
                               input logic [W-1:0] lv, input logic e,
                               input logic ar);
    reset       = r;
    load        = ld;
    load_value  = lv;
    en          = e;
    auto_reload = ar;
    @(posedge clk);
    model_edge();
    #1;
    check("model_q", 32'(q), 32'(m_q));
    check("model_tc", 32'(tc), 32'(m_tc));
    check("model_busy", 32'(busy), 32'(m_run));
    if (tc === 1'b1) tc_seen++;
  endtask

  // Compare the current outputs against hand-derived constants.
  task automatic checkOutput(input string tag, input int exp_q,
                             input int exp_tc, input int exp_busy);
    check({tag, "_q"}, 32'(q), 32'(exp_q));
    check({tag, "_tc"}, 32'(tc), 32'(exp_tc));
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
  endtask

  initial begin
    int oneshot_q[6];
    int periodic_q[7];
    int periodic_tc[7];
    int gate_en[6];
    int gate_q[6];

    checks   = 0;
    failures = 0;
    tc_seen  = 0;
    m_q = 0; m_rl = 0; m_run = 0; m_tc = 0;

    // Reset wins over a simultaneous load.
    applyStimulus(1, 1, 4'd9, 1, 0);
    checkOutput("reset1", 0, 0, 0);
    applyStimulus(1, 1, 4'd9, 1, 0);
    checkOutput("reset2", 0, 0, 0);

    // One-shot countdown from 5.
    oneshot_q = '{5, 4, 3, 2, 1, 0};
    applyStimulus(0, 1, 4'd5, 1, 0);
    checkOutput("oneshot0", oneshot_q[0], 0, 1);
    for (int i = 1; i < 6; i++) begin
      applyStimulus(0, 0, 4'd0, 1, 0);
      checkOutput($sformatf("oneshot%0d", i), oneshot_q[i],
                  (i == 5) ? 1 : 0, (i == 5) ? 0 : 1);
    end
    applyStimulus(0, 0, 4'd0, 1, 0);
    checkOutput("oneshot_hold", 0, 0, 0);

    // Periodic mode with N=3.
    periodic_q  = '{3, 2, 1, 3, 2, 1, 3};
    periodic_tc = '{0, 0, 0, 1, 0, 0, 1};
    applyStimulus(0, 1, 4'd3, 1, 1);
    checkOutput("periodic0", periodic_q[0], periodic_tc[0], 1);
    for (int i = 1; i < 7; i++) begin
      applyStimulus(0, 0, 4'd0, 1, 1);
      checkOutput($sformatf("periodic%0d", i), periodic_q[i],
                  periodic_tc[i], 1);
    end

    // Periodic mode with N=1 pulses every cycle.
    applyStimulus(0, 1, 4'd1, 1, 1);
    checkOutput("period1_load", 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 4'd0, 1, 1);
      checkOutput("period1", 1, 1, 1);
    end

    // Enable gating stretches the count.
    gate_en = '{1, 0, 0, 1, 1, 1};
    gate_q  = '{3, 3, 3, 2, 1, 0};
    applyStimulus(0, 1, 4'd4, 1, 0);
    checkOutput("gate_load", 4, 0, 1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 4'd0, logic'(gate_en[i]), 0);
      checkOutput($sformatf("gate%0d", i), gate_q[i],
                  (i == 5) ? 1 : 0, (i == 5) ? 0 : 1);
    end

    // Load on the terminal edge wins and suppresses tc.
    applyStimulus(0, 1, 4'd2, 1, 0);
    applyStimulus(0, 0, 4'd0, 1, 0);
    checkOutput("coll_pre", 1, 0, 1);
    applyStimulus(0, 1, 4'd7, 1, 0);
    checkOutput("coll_load7", 7, 0, 1);

    // Load of zero while running goes idle without tc.
    applyStimulus(0, 1, 4'd0, 1, 0);
    checkOutput("coll_load0", 0, 0, 0);
    applyStimulus(0, 0, 4'd0, 1, 0);
    checkOutput("load0_idle", 0, 0, 0);

    // Full-scale one-shot: 15 decrements and a single tc pulse.
    applyStimulus(0, 1, 4'd15, 1, 0);
    checkOutput("full_load", 15, 0, 1);
    tc_seen = 0;
    for (int i = 0; i < 15; i++) applyStimulus(0, 0, 4'd0, 1, 0);
    checkOutput("full_end", 0, 1, 0);
    applyStimulus(0, 0, 4'd0, 1, 0);
    check("full_tc_pulses", 32'(tc_seen), 32'd1);

    // Reset in the middle of a run.
    applyStimulus(0, 1, 4'd9, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'd0, 1, 0);
    checkOutput("mid_pre", 6, 0, 1);
    applyStimulus(1, 0, 4'd0, 1, 0);
    checkOutput("mid_reset", 0, 0, 0);

    // Reset also clears the reload value: a pending periodic reload after a
    // reset-then-load must use the new value.
    applyStimulus(0, 1, 4'd2, 1, 1);
    applyStimulus(0, 0, 4'd0, 1, 1);
    applyStimulus(0, 0, 4'd0, 1, 1);
    checkOutput("reload_after_reset", 2, 1, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(logic'($urandom_range(0, 39) == 0),
                    logic'($urandom_range(0, 7) == 0),
                    W'($urandom_range(0, 15)),
                    logic'($urandom_range(0, 3) != 0),
                    logic'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sync_down_counter
